lru_requester4: RTL

Requester-side front end for the 4-port LRU arbiter. It accepts per-client transfer requests into saturating pending counters and drives `req_vector` to the arbiter. It consumes the returned `grant_vector`, then locks ownership for a fixed burst of beats before retiring the request. It sits between four client ports and the arbiter and shares the arbiter's `clk` and `enable`.

---
 rtl/lru_requester4.sv | 133 +++++++++++++
 1 files changed

// File: rtl/lru_requester4.sv
// Requester front end for the 4-port LRU arbiter: per-client saturating pending
// counters feed req_vector, and a granted client owns a fixed burst of beats.
module lru_requester4 #(
   parameter int PEND_W = 3,
   parameter int BURST  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] push,
   output logic [3:0] full,
   output logic [3:0] req_vector,
   input  logic [3:0] grant_vector,
   output logic       beat_valid,
   output logic [1:0] beat_owner,
   output logic [3:0] beat_idx,
   output logic [3:0] done,
   output logic       err_grant
);

   // state    | meaning
   // ST_ARB   | requests driven to the arbiter, waiting for a legal grant
   // ST_BURST | owner locked, one beat per enabled cycle until BURST beats
   typedef enum logic {ST_ARB = 1'b0, ST_BURST = 1'b1} state_t;

   localparam logic [PEND_W-1:0] PEND_MAX  = '1;
   localparam logic [3:0]        BEAT_LAST = 4'(BURST - 1);

   state_t            state_q, state_d;
   logic [PEND_W-1:0] pend_q [4];
   logic [PEND_W-1:0] pend_d [4];
   logic [1:0]        owner_q, owner_d;
   logic [3:0]        beat_q, beat_d;
   logic [3:0]        done_q, done_d;
   logic              err_q, err_d;
   logic              retire;
   logic              grant_ok;
   logic [1:0]        grant_idx;

   always_comb begin
      req_vector = '0;
      full       = '0;
      for (int i = 0; i < 4; i++) begin
         req_vector[i] = (state_q == ST_ARB) && (pend_q[i] != '0);
         full[i]       = (pend_q[i] == PEND_MAX);
      end
   end

   assign beat_valid = (state_q == ST_BURST) && enable;
   assign beat_owner = owner_q;
   assign beat_idx   = beat_q;
   assign done       = done_q;
   assign err_grant  = err_q;

   always_comb begin
      case (grant_vector)
         4'b0010: grant_idx = 2'd1;
         4'b0100: grant_idx = 2'd2;
         4'b1000: grant_idx = 2'd3;
         default: grant_idx = 2'd0;
      endcase
   end

   // Legal grant: exactly one bit set, and that client is actually requesting.
   assign grant_ok = (grant_vector != '0)
                  && ((grant_vector & (grant_vector - 4'd1)) == '0)
                  && ((grant_vector & req_vector) != '0);

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      beat_d  = beat_q;
      done_d  = '0;
      err_d   = 1'b0;
      retire  = 1'b0;
      case (state_q)
         ST_ARB: begin
            if (enable && (grant_vector != '0)) begin
               if (grant_ok) begin
                  owner_d = grant_idx;
                  beat_d  = '0;
                  state_d = ST_BURST;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_BURST: begin
            if (enable) begin
               if (beat_q == BEAT_LAST) begin
                  retire          = 1'b1;
                  done_d[owner_q] = 1'b1;
                  state_d         = ST_ARB;
               end else begin
                  beat_d = beat_q + 4'd1;
               end
            end
         end
         default: state_d = ST_ARB;
      endcase
   end

   // A push landing on the retiring client cancels the decrement, even when full.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         pend_d[i] = pend_q[i];
         if (retire && (owner_q == 2'(i))) begin
            if (!push[i]) pend_d[i] = pend_q[i] - PEND_W'(1);
         end else if (push[i] && (pend_q[i] != PEND_MAX)) begin
            pend_d[i] = pend_q[i] + PEND_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_ARB;
         owner_q <= '0;
         beat_q  <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < 4; i++) pend_q[i] <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         beat_q  <= beat_d;
         done_q  <= done_d;
         err_q   <= err_d;
         for (int i = 0; i < 4; i++) pend_q[i] <= pend_d[i];
      end
   end

endmodule
